text_line_writer: RTL

//  Writer side of the character path: accepts ASCII bytes over a valid/ready stream,

---
 rtl/text_line_writer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/text_line_writer.sv
// rtl/text_line_writer.sv - ASCII byte stream to glyph-offset text-cell RAM writer
// Owns cursor movement, wrap, backspace, CR and form-feed clear; renderers read cells back.
module text_line_writer #(
    parameter int NUM_CELLS = 16,
    parameter int CELL_W    = $clog2(NUM_CELLS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic [CELL_W-1:0] rd_cell,
    output logic [8:0]        rd_offset,
    output logic [CELL_W-1:0] cursor,
    output logic              wrapped,
    output logic              busy
);

    localparam logic [CELL_W-1:0] LAST  = CELL_W'(NUM_CELLS - 1);
    localparam logic [CELL_W-1:0] ONE   = CELL_W'(1);
    localparam logic [8:0]        SPACE = 9'h100;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CELL_W-1:0] clr_idx;
    logic [8:0]        mem [NUM_CELLS];

    logic              accept;
    logic              is_cr;
    logic              is_bs;
    logic              is_ff;
    logic              is_char;
    logic              rd_in_range;
    logic              wr_en;
    logic [CELL_W-1:0] wr_addr;
    logic [8:0]        wr_data;

    // Letters map by their low five bits, digits/punctuation by their low six;
    // everything else renders as the space glyph.
    function automatic logic [8:0] glyph(input logic [7:0] b);
        if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
            return {1'b0, b[4:0], 3'b000};
        else if (b >= 8'h20 && b <= 8'h3F)
            return {b[5:0], 3'b000};
        else
            return SPACE;
    endfunction

    assign accept  = in_valid && (state == S_IDLE);
    assign is_cr   = (in_data == 8'h0D);
    assign is_bs   = (in_data == 8'h08);
    assign is_ff   = (in_data == 8'h0C);
    assign is_char = !(is_cr || is_bs || is_ff);

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_CLEAR;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_CLEAR: if (clr_idx == LAST) state_nx = S_IDLE;
            S_IDLE:  if (accept && is_ff) state_nx = S_CLEAR;
            default: state_nx = S_CLEAR;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = clr_idx;
        wr_data  = SPACE;
        case (state)
            S_CLEAR: begin
                busy  = 1'b1;
                wr_en = 1'b1;
            end
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (is_bs) begin
                        if (cursor != '0) begin
                            wr_en   = 1'b1;
                            wr_addr = cursor - ONE;
                        end
                    end else if (is_char) begin
                        wr_en   = 1'b1;
                        wr_addr = cursor;
                        wr_data = glyph(in_data);
                    end
                end
            end
            default: busy = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cursor  <= '0;
            clr_idx <= '0;
            wrapped <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            if (state == S_CLEAR) begin
                clr_idx <= (clr_idx == LAST) ? '0 : clr_idx + ONE;
            end else if (accept) begin
                if (is_cr) begin
                    cursor <= '0;
                end else if (is_ff) begin
                    cursor  <= '0;
                    clr_idx <= '0;
                end else if (is_bs) begin
                    if (cursor != '0)
                        cursor <= cursor - ONE;
                end else if (cursor == LAST) begin
                    cursor  <= '0;
                    wrapped <= 1'b1;
                end else begin
                    cursor <= cursor + ONE;
                end
            end
        end
    end

    // The reset cycle must not leave a half-finished write behind.
    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            mem[wr_addr] <= wr_data;
    end

    generate
        if (NUM_CELLS == (1 << CELL_W)) begin : g_full_range
            assign rd_in_range = 1'b1;
        end else begin : g_part_range
            assign rd_in_range = (rd_cell <= LAST);
        end
    endgenerate

    // Non-blocking read alongside the write gives read-before-write on a shared cell.
    always_ff @(posedge clk) begin
        if (rst)
            rd_offset <= SPACE;
        else
            rd_offset <= rd_in_range ? mem[rd_cell] : SPACE;
    end

endmodule
